png_frm_ctl: RTL
================

Name: png_frm_ctl

Overview:
Frame-level sequencer for the PNG encoder pipeline (filter -> fifo_flt -> lz77 -> bs, with adler32/crc32 alongside).
- Accepts one frame request, latches the frame geometry, and issues staged start pulses to each stage.
- Counts input pixels and aggregates the per-stage done signals into a single frame done.
- Detects configuration errors, pixel overruns and stalls (watchdog timeout).

Parameters:
W_WD, 12, width of the frame-width config.
H_WD, 12, width of the frame-height config.
TMO_WD, 20, watchdog counter width; timeout fires after 2^TMO_WD-1 idle-progress cycles.

Ports:
clk  input  1  clock.
rstn  input  1  asynchronous active-low reset.
cfg_w_i  input  W_WD  frame width in pixels; sampled only on an accepted start.
cfg_h_i  input  H_WD  frame height in pixels; sampled only on an accepted start.
start_i  input  1  frame request pulse.
val_i  input  1  input pixel strobe (same strobe that feeds the filter).
flt_done_i  input  1  filter done pulse.
lz_done_i  input  1  lz77 done pulse.
bs_done_i  input  1  bitstream done pulse.
flt_start_o  output  1  start pulse to filter.
bs_start_o  output  1  start pulse to bs, adler32 and crc32.
lz_start_o  output  1  start pulse to lz77.
cfg_w_o  output  W_WD  latched width, held stable for the whole frame.
cfg_h_o  output  H_WD  latched height, held stable for the whole frame.
busy_o  output  1  frame in progress.
done_o  output  1  frame-complete pulse.
err_o  output  1  sticky error flag.
err_code_o  output  2  error code: 0 none, 1 zero geometry, 2 timeout, 3 pixel overrun.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE; pixel counter, watchdog and latched cfg are cleared.
- Output timing: all outputs are registered. Every start pulse is exactly 1 cycle wide.
- States: IDLE, FILT, LZ, TAIL, DONE, ERR. busy_o = 1 in FILT, LZ and TAIL.
- IDLE:
  - start_i with cfg_w_i != 0 and cfg_h_i != 0:
    - latch cfg and compute npix = w*h (W_WD+H_WD bits).
    - clear err_o and err_code_o.
    - next cycle: flt_start_o = bs_start_o = 1; state goes to FILT.
  - start_i with w == 0 or h == 0: go to ERR, err_o = 1, err_code_o = 1.
- FILT:
  - Each val_i increments pix_cnt.
  - val_i while pix_cnt == npix: go to ERR, err_code_o = 3.
  - flt_done_i: next cycle lz_start_o = 1; state goes to LZ.
  - Simultaneous flt_done_i and an overrun val_i: the error wins.
- LZ:
  - lz_done_i: go to TAIL.
  - lz_done_i together with bs_done_i in the same cycle: go directly to DONE.
  - A bs_done_i arriving earlier in LZ is latched (bs_seen); lz_done_i then goes directly to DONE.
- TAIL: bs_done_i goes to DONE.
- DONE:
  - done_o = 1 for one cycle, then return to IDLE.
  - Latched cfg remains on cfg_w_o/cfg_h_o until the next accepted start.
- Watchdog:
  - Runs in FILT, LZ and TAIL.
  - Cleared on state entry and on any val_i or any done input.
  - Saturating at all-ones goes to ERR with err_code_o = 2.
- ERR:
  - err_o stays high and start outputs stay low.
  - The next start_i is treated exactly as in IDLE; it clears err_o only if accepted.
- start_i while busy or in DONE: ignored, with no side effects.
- Done inputs arriving in an unexpected state (e.g. lz_done_i in FILT, anything in IDLE) are ignored; exception: bs_done_i in FILT or LZ sets bs_seen.
- Asynchronous reset in any state aborts the frame immediately; no done_o is produced.

Optional Feature:
PNG_FRM_CTL_STAT_EN
- Defined:
  - Adds output cyc_cnt_o [31:0].
  - A free-running counter clears on the accepted start and counts every cycle while busy_o.
  - Its value is captured into cyc_cnt_o in the cycle done_o rises and held until the next capture.
  - cyc_cnt_o resets to 0 and saturates at 0xFFFFFFFF.
- Undefined: the port and the logic are absent; all other behaviour is identical.

Test Plan:
- Nominal frame: w=4, h=2, start; 8 val_i; flt_done 5 cycles later; lz_done at +20; bs_done at +30.
  -> flt_start_o and bs_start_o at start+1; lz_start_o exactly 1 cycle after flt_done; done_o 1 cycle after bs_done; busy_o low afterwards; err_o=0.
- Zero geometry: start with w=0, h=5 -> no start pulses; err_o=1, err_code_o=1; a following start with w=2, h=2 is accepted and clears err_o.
- Pixel overrun: w=2, h=2, 5 val_i -> ERR on the 5th strobe; err_code_o=3; no lz_start_o.
- Done ordering: bs_done before lz_done -> done_o 1 cycle after lz_done. Same-cycle lz_done/bs_done -> done_o next cycle; TAIL is never entered.
- Watchdog: with TMO_WD=4, stall in LZ -> err_code_o=2 after 15 cycles without progress. A start_i mid-frame is ignored, with start outputs unchanged.
- Reset mid-frame in TAIL -> all outputs 0 immediately; no done_o. With PNG_FRM_CTL_STAT_EN, the nominal frame gives cyc_cnt_o equal to the measured busy cycles.

Source files
------------

// File: rtl/png_frm_ctl.sv
// png_frm_ctl - frame-level sequencer for the PNG encoder pipeline
// (filter -> fifo_flt -> lz77 -> bs, with adler32/crc32 alongside).
//
// Accepts one frame request, latches the geometry, issues staged start
// pulses, counts input pixels, merges the per-stage done pulses into one
// frame done, and flags zero geometry, pixel overrun and watchdog stalls.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cfg_w_i, cfg_h_i          frame geometry, sampled on an accepted start
//   start_i                   frame request pulse
//   val_i                     input pixel strobe
//   flt_done_i, lz_done_i,
//   bs_done_i                 per-stage done pulses
//   flt_start_o               start pulse to filter
//   bs_start_o                start pulse to bs, adler32 and crc32
//   lz_start_o                start pulse to lz77
//   cfg_w_o, cfg_h_o          latched geometry, stable for the whole frame
//   busy_o                    frame in progress
//   done_o                    frame-complete pulse
//   err_o, err_code_o         sticky error flag and code
//                             (0 none, 1 zero geometry, 2 timeout, 3 overrun)
//   cyc_cnt_o                 busy-cycle count of the last completed frame
//                             (only with PNG_FRM_CTL_STAT_EN defined)
//
// Optional feature macro: PNG_FRM_CTL_STAT_EN
module png_frm_ctl #(
    parameter int W_WD   = 12,
    parameter int H_WD   = 12,
    parameter int TMO_WD = 20
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [W_WD-1:0] cfg_w_i,
    input  logic [H_WD-1:0] cfg_h_i,
    input  logic            start_i,
    input  logic            val_i,
    input  logic            flt_done_i,
    input  logic            lz_done_i,
    input  logic            bs_done_i,
    output logic            flt_start_o,
    output logic            bs_start_o,
    output logic            lz_start_o,
    output logic [W_WD-1:0] cfg_w_o,
    output logic [H_WD-1:0] cfg_h_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [1:0]      err_code_o
`ifdef PNG_FRM_CTL_STAT_EN
    ,
    output logic [31:0]     cyc_cnt_o
`endif
);

    localparam int NP_WD = W_WD + H_WD;
    localparam logic [TMO_WD-1:0] WD_MAX  = '1;
    // Firing on the stall that would make the counter all-ones gives
    // exactly 2^TMO_WD-1 stalled cycles before entering ERR.
    localparam logic [TMO_WD-1:0] WD_LAST = WD_MAX - TMO_WD'(1);

    typedef enum logic [2:0] {
        IDLE,
        FILT,
        LZ,
        TAIL,
        DONE,
        ERR
    } state_t;

    state_t state, state_nx;

    logic [NP_WD-1:0]  npix;
    logic [NP_WD-1:0]  pix_cnt;
    logic [TMO_WD-1:0] wd_cnt;
    logic              bs_seen;

    logic in_busy, geom_ok, can_start, accept, reject;
    logic progress, overrun, wd_fire;

    // Condition decode and next-state logic
    always_comb begin
        in_busy   = (state == FILT) || (state == LZ) || (state == TAIL);
        progress  = val_i || flt_done_i || lz_done_i || bs_done_i;
        geom_ok   = (cfg_w_i != '0) && (cfg_h_i != '0);
        can_start = (state == IDLE) || (state == ERR);
        accept    = can_start && start_i && geom_ok;
        reject    = can_start && start_i && !geom_ok;
        overrun   = (state == FILT) && val_i && (pix_cnt == npix);
        wd_fire   = in_busy && !progress && (wd_cnt == WD_LAST);

        state_nx = state;
        case (state)
            IDLE, ERR: begin
                if (accept)      state_nx = FILT;
                else if (reject) state_nx = ERR;
            end
            FILT: begin
                // overrun beats a simultaneous flt_done
                if (overrun)         state_nx = ERR;
                else if (flt_done_i) state_nx = LZ;
                else if (wd_fire)    state_nx = ERR;
            end
            LZ: begin
                if (lz_done_i)    state_nx = (bs_done_i || bs_seen) ? DONE : TAIL;
                else if (wd_fire) state_nx = ERR;
            end
            TAIL: begin
                if (bs_done_i)    state_nx = DONE;
                else if (wd_fire) state_nx = ERR;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Registered outputs, derived from the transition being taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flt_start_o <= 1'b0;
            bs_start_o  <= 1'b0;
            lz_start_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            cfg_w_o     <= '0;
            cfg_h_o     <= '0;
            err_o       <= 1'b0;
            err_code_o  <= 2'd0;
        end else begin
            flt_start_o <= accept;
            bs_start_o  <= accept;
            lz_start_o  <= (state == FILT) && (state_nx == LZ);
            busy_o      <= (state_nx == FILT) || (state_nx == LZ) || (state_nx == TAIL);
            done_o      <= (state_nx == DONE);
            if (accept) begin
                cfg_w_o    <= cfg_w_i;
                cfg_h_o    <= cfg_h_i;
                err_o      <= 1'b0;
                err_code_o <= 2'd0;
            end else if (reject) begin
                err_o      <= 1'b1;
                err_code_o <= 2'd1;
            end else if (overrun) begin
                err_o      <= 1'b1;
                err_code_o <= 2'd3;
            end else if (wd_fire) begin
                err_o      <= 1'b1;
                err_code_o <= 2'd2;
            end
        end
    end

    // Frame datapath: pixel count, bs_seen latch, watchdog
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            npix    <= '0;
            pix_cnt <= '0;
            bs_seen <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            if (accept) begin
                npix    <= NP_WD'(cfg_w_i) * NP_WD'(cfg_h_i);
                pix_cnt <= '0;
                bs_seen <= 1'b0;
            end else begin
                if ((state == FILT) && val_i && !overrun)
                    pix_cnt <= pix_cnt + NP_WD'(1);
                if (((state == FILT) || (state == LZ)) && bs_done_i)
                    bs_seen <= 1'b1;
            end
            if (!in_busy || (state_nx != state) || progress)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + TMO_WD'(1);
        end
    end

`ifdef PNG_FRM_CTL_STAT_EN
    logic [31:0] cyc_run;
    logic [31:0] cyc_inc;

    // Includes the current busy cycle so the captured value covers the
    // whole frame, including the cycle in which done_o is being raised.
    always_comb begin
        cyc_inc = cyc_run;
        if (busy_o && (cyc_run != '1))
            cyc_inc = cyc_run + 32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_run   <= '0;
            cyc_cnt_o <= '0;
        end else begin
            if (accept) cyc_run <= '0;
            else        cyc_run <= cyc_inc;
            if (state_nx == DONE)
                cyc_cnt_o <= cyc_inc;
        end
    end
`endif

endmodule
